// File: rtl/prm_edge_query_seq.sv
// Issues contiguous 15-bit query codes to a combinational obstacle checker, captures the
// returned edge_mask bits and streams them packed PACK bits per word.
module prm_edge_query_seq #(
  parameter int unsigned QW      = 15,
  parameter int unsigned PACK    = 32,
  parameter int unsigned CHK_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [QW-1:0]   base_i,
  input  logic [15:0]     count_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [QW-1:0]   query_o,
  output logic            query_vld_o,
  input  logic            mask_i,
  output logic [PACK-1:0] word_o,
  output logic            word_vld_o,
  input  logic            word_rdy_i,
  output logic            word_last_o,
  output logic [15:0]     blocked_cnt_o
);

  localparam int unsigned FW = $clog2(PACK + 1);
  localparam int unsigned IW = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StFlush, StDone} state_e;

  state_e              state_q, state_d;
  logic [QW-1:0]       query_q;
  logic [15:0]         count_q;
  logic [15:0]         issued_q;
  logic [15:0]         captured_q;
  logic [CHK_LAT-1:0]  pipe_q, pipe_d;
  logic [CHK_LAT:0]    pipe_ext;
  logic [FW-1:0]       fill_q, fill_cap, inflight;
  logic [PACK-1:0]     pack_q, pack_cap;
  logic [PACK-1:0]     word_q;
  logic                word_vld_q, word_last_q;
  logic [15:0]         blocked_q;
  logic                busy_q, done_q;

  logic                capture, out_free, stall, start_ok, issue;
  logic                move_full, move_flush, done_d;
  logic [15:0]         cap_total;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < CHK_LAT; i++) begin
      inflight = inflight + FW'(pipe_q[i]);
    end
  end

  assign capture  = pipe_q[CHK_LAT-1];
  assign out_free = ~word_vld_q | word_rdy_i;
  // Hold off a query whose result would land past a full pack word that cannot move out.
  assign stall    = ((32'(fill_q) + 32'(inflight) + 32'd1) > PACK) && !out_free;
  assign start_ok = (state_q == StIdle) && start_i && !done_q;
  assign issue    = (state_q == StIssue) && !stall;

  assign pipe_ext = {pipe_q, issue};
  assign pipe_d   = pipe_ext[CHK_LAT-1:0];

  always_comb begin
    pack_cap = pack_q;
    if (capture) begin
      pack_cap[fill_q[IW-1:0]] = mask_i;
    end
  end

  assign fill_cap   = fill_q + FW'(capture);
  assign cap_total  = captured_q + 16'(capture);
  assign move_flush = (state_q == StFlush) && out_free;
  assign move_full  = (fill_cap == FW'(PACK)) && out_free;
  assign done_d     = (state_q == StDone) && out_free;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = (count_i == 16'd0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        if (issue && ((issued_q + 16'd1) == count_q)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (pipe_q == '0) begin
          state_d = (move_full || (fill_q == '0)) ? StDone : StFlush;
        end
      end
      StFlush: begin
        if (out_free) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_free) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      query_q     <= '0;
      count_q     <= '0;
      issued_q    <= '0;
      captured_q  <= '0;
      pipe_q      <= '0;
      fill_q      <= '0;
      pack_q      <= '0;
      word_q      <= '0;
      word_vld_q  <= 1'b0;
      word_last_q <= 1'b0;
      blocked_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      pipe_q <= pipe_d;
      done_q <= done_d;

      if (start_ok) begin
        query_q    <= base_i;
        count_q    <= count_i;
        issued_q   <= '0;
        captured_q <= '0;
        blocked_q  <= '0;
        busy_q     <= 1'b1;
      end else begin
        if (issue) begin
          query_q  <= query_q + 1'b1;
          issued_q <= issued_q + 16'd1;
        end
        captured_q <= cap_total;
        if (capture && mask_i) begin
          blocked_q <= blocked_q + 16'd1;
        end
        if (done_d) begin
          busy_q <= 1'b0;
        end
      end

      if (move_flush) begin
        word_q      <= pack_q;
        word_vld_q  <= 1'b1;
        word_last_q <= 1'b1;
        pack_q      <= '0;
        fill_q      <= '0;
      end else if (move_full) begin
        // A full word is last only if it carries the job's final result.
        word_q      <= pack_cap;
        word_vld_q  <= 1'b1;
        word_last_q <= (cap_total == count_q);
        pack_q      <= '0;
        fill_q      <= '0;
      end else begin
        pack_q <= pack_cap;
        fill_q <= fill_cap;
        if (word_vld_q && word_rdy_i) begin
          word_vld_q  <= 1'b0;
          word_last_q <= 1'b0;
        end
      end
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign query_o       = query_q;
  assign query_vld_o   = issue;
  assign word_o        = word_q;
  assign word_vld_o    = word_vld_q;
  assign word_last_o   = word_last_q;
  assign blocked_cnt_o = blocked_q;

endmodule

// File: tb/tb_prm_edge_query_seq.sv
// Randomized bench for prm_edge_query_seq: a latency-accurate checker stand-in drives mask_i
// and a list-based model predicts query codes, packed words and the blocked count.
module tb_prm_edge_query_seq;

  localparam int QW    = 15;
  localparam int PACK  = 32;
  localparam int LAT   = 2;
  localparam int LIMIT = 20000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic [QW-1:0]   base_i = '0;
  logic [15:0]     count_i = '0;
  logic            busy_o, done_o, query_vld_o;
  logic [QW-1:0]   query_o;
  logic            mask_i = 1'b0;
  logic [PACK-1:0] word_o;
  logic            word_vld_o, word_last_o;
  logic            word_rdy_i = 1'b1;
  logic [15:0]     blocked_cnt_o;

  always #5 clk = ~clk;

  prm_edge_query_seq #(
    .QW      (QW),
    .PACK    (PACK),
    .CHK_LAT (LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .base_i        (base_i),
    .count_i       (count_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .query_o       (query_o),
    .query_vld_o   (query_vld_o),
    .mask_i        (mask_i),
    .word_o        (word_o),
    .word_vld_o    (word_vld_o),
    .word_rdy_i    (word_rdy_i),
    .word_last_o   (word_last_o),
    .blocked_cnt_o (blocked_cnt_o)
  );

  bit          lut [0:32767];
  int          n_checks = 0;
  int          n_errors = 0;
  int          fmode = 0;
  int          rmode = 0;
  int          job_cyc = 0;
  int          cyc = 0;
  logic [14:0] exp_code = '0;
  int          exp_blocked, exp_nwords;
  int          n_issued, n_words, n_done, busy_cycles;
  int          first_q_cyc, last_q_cyc, last_hs_cyc, done_cyc;
  logic [32:0] exp_words [$];
  logic [15:0] hist [$];
  bit          poke = 1'b0;
  bit          hold_pending = 1'b0;
  logic [32:0] held = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_mask(input logic [14:0] code);
    return (fmode == 0) ? code[0] : lut[code];
  endfunction

  // Observe away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      cyc++;
      if (busy_o) busy_cycles++;
      if (query_vld_o) begin
        check_eq("query_code", 64'(query_o), 64'(exp_code));
        exp_code = exp_code + 1'b1;
        n_issued++;
        if (n_issued == 1) first_q_cyc = cyc;
        last_q_cyc = cyc;
      end
      if (word_vld_o && hold_pending) check_eq("word_hold", 64'({word_last_o, word_o}), 64'(held));
      if (word_vld_o && word_rdy_i) begin
        n_words++;
        last_hs_cyc  = cyc;
        hold_pending = 1'b0;
        if (exp_words.size() == 0) begin
          check_eq("word_extra", 64'(n_words), 64'd0);
        end else begin
          held = exp_words.pop_front();
          check_eq("word_data", 64'(word_o), 64'(held[31:0]));
          check_eq("word_last", 64'(word_last_o), 64'(held[32]));
        end
      end else if (word_vld_o) begin
        hold_pending = 1'b1;
        held = {word_last_o, word_o};
      end else begin
        hold_pending = 1'b0;
      end
      if (done_o) begin
        n_done++;
        done_cyc = cyc;
      end
      hist.push_front({query_vld_o, query_o});
      if (hist.size() > 8) void'(hist.pop_back());
    end
  end

  // Checker stand-in with LAT cycles of latency, plus consumer ready pattern.
  always @(posedge clk) begin
    #1;
    job_cyc++;
    case (rmode)
      0:       word_rdy_i = 1'b1;
      1:       word_rdy_i = ($urandom_range(0, 3) != 0);
      default: word_rdy_i = !(job_cyc >= 10 && job_cyc <= 60);
    endcase
    if (hist.size() >= LAT && hist[LAT-1][15]) mask_i = model_mask(hist[LAT-1][14:0]);
    else mask_i = 1'($urandom_range(0, 1));
  end

  task automatic start_job(input logic [14:0] base, input int cnt, input int rm, input int fm);
    logic [31:0] w;
    logic [14:0] code;
    bit          b;
    int          nb;
    w  = '0;
    nb = 0;
    fmode = fm;
    rmode = rm;
    exp_words.delete();
    for (int k = 0; k < cnt; k++) begin
      code = base + 15'(k);
      b = model_mask(code);
      w[k % PACK] = b;
      nb += int'(b);
      if ((k % PACK) == PACK - 1 || k == cnt - 1) begin
        exp_words.push_back({(k == cnt - 1), w});
        w = '0;
      end
    end
    exp_blocked  = nb;
    exp_nwords   = (cnt + PACK - 1) / PACK;
    exp_code     = base;
    n_issued     = 0;
    n_words      = 0;
    n_done       = 0;
    busy_cycles  = 0;
    first_q_cyc  = 0;
    last_q_cyc   = 0;
    last_hs_cyc  = 0;
    done_cyc     = 0;
    hold_pending = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1;
    base_i  = base;
    count_i = 16'(cnt);
    job_cyc = 0;
    @(posedge clk); #1;
    start_i = 1'b0;
    check_eq("busy_after_start", 64'(busy_o), 64'd1);
  endtask

  task automatic finish_job(input int cnt);
    int t;
    t = 0;
    while (n_done == 0 && t < LIMIT) begin
      @(posedge clk); #1;
      t++;
      start_i = poke && ((busy_o && (t % 7 == 3)) || done_o);
      if (start_i && busy_o) begin
        base_i  = 15'($urandom);
        count_i = 16'($urandom_range(1, 40));
      end
    end
    start_i = 1'b0;
    if (n_done == 0) check_eq("done_timeout", 64'd0, 64'd1);
    check_eq("busy_after_done", 64'(busy_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_pulses", 64'(n_done), 64'd1);
    check_eq("issued", 64'(n_issued), 64'(cnt));
    check_eq("words_left", 64'(exp_words.size()), 64'd0);
    check_eq("word_count", 64'(n_words), 64'(exp_nwords));
    check_eq("blocked_cnt", 64'(blocked_cnt_o), 64'(exp_blocked));
    check_eq("idle_busy_vld", 64'({busy_o, word_vld_o, query_vld_o}), 64'd0);
    if (cnt > 0) begin
      check_eq("done_after_hs",
               64'((done_cyc > last_hs_cyc) && (done_cyc - last_hs_cyc <= 3)), 64'd1);
    end
  endtask

  task automatic run_job(input logic [14:0] base, input int cnt, input int rm, input int fm);
    start_job(base, cnt, rm, fm);
    finish_job(cnt);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) lut[i] = 1'($urandom_range(0, 1));
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_outputs", 64'({busy_o, done_o, query_vld_o, word_vld_o, word_last_o}), 64'd0);
    check_eq("rst_query", 64'(query_o), 64'd0);
    check_eq("rst_blocked", 64'(blocked_cnt_o), 64'd0);
    rst = 1'b0;

    // Wrap-around job with a directly known answer.
    run_job(15'h7FFE, 5, 0, 0);
    check_eq("t1_word_literal", 64'(n_words), 64'd1);
    check_eq("t1_blocked_literal", 64'(blocked_cnt_o), 64'd2);
    check_eq("t1_done_lat", 64'(done_cyc - last_hs_cyc), 64'd1);

    run_job(15'h0000, 64, 0, 1);
    check_eq("t2_issue_span", 64'(last_q_cyc - first_q_cyc + 1), 64'd64);

    run_job(15'($urandom), 100, 2, 1);

    run_job(15'($urandom), 0, 0, 1);
    check_eq("t4_busy_cycles", 64'(busy_cycles), 64'd1);

    poke = 1'b1;
    run_job(15'($urandom), 80, 1, 1);
    poke = 1'b0;

    run_job(15'($urandom), 32, 1, 1);
    run_job(15'($urandom), 33, 1, 1);

    // Abort mid-issue.
    start_job(15'h1234, 1000, 1, 1);
    repeat (60) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("abort_ctrl", 64'({busy_o, done_o, query_vld_o, word_vld_o, word_last_o}), 64'd0);
    check_eq("abort_data", 64'({word_o, query_o}), 64'd0);
    check_eq("abort_blocked", 64'(blocked_cnt_o), 64'd0);
    check_eq("abort_no_done", 64'(n_done), 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_words.delete();
    hist.delete();
    run_job(15'h7FF0, 40, 1, 1);

    for (int j = 0; j < 8; j++) begin
      run_job(15'($urandom), $urandom_range(1, 150), 1, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
